// File: rtl/hazard_unit.sv
// Stall, flush and forwarding control for the 5-stage MIPS pipeline, with a multi-cycle EX busy FSM.
// Optional `HAZARD_PERF_CNT_EN adds loadStallCnt/mdStallCnt performance counters.
module hazard_unit #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        branchD,
  input  logic        branchTakenD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeRegE,
  input  logic        Regfile_weE,
  input  logic        memToRegE,
  input  logic        mdStartE,
  input  logic [4:0]  writeRegM,
  input  logic        Regfile_weM,
  input  logic        memToRegM,
  input  logic [4:0]  writeRegW,
  input  logic        Regfile_weW,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        forwardAD,
  output logic        forwardBD,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] loadStallCnt,
  output logic [31:0] mdStallCnt,
`endif
  output logic        mdBusy
);

  localparam int unsigned CntW = $clog2(MD_LATENCY);
  localparam logic [CntW-1:0] CntLoad = CntW'(MD_LATENCY - 2);

  typedef enum logic {StIdle, StMdBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            md_stall;
  logic            lw_stall;
  logic            br_stall;
  logic            any_stall;

  // Register 0 is hardwired, so it never forwards or creates a hazard.
  function automatic logic match(input logic [4:0] x, input logic [4:0] r, input logic we);
    return we && (x != 5'd0) && (x == r);
  endfunction

  always_comb begin
    lw_stall = memToRegE &&
               (match(writeRegE, rsD, Regfile_weE) || match(writeRegE, rtD, Regfile_weE));
    br_stall = branchD &&
               (match(writeRegE, rsD, Regfile_weE) || match(writeRegE, rtD, Regfile_weE) ||
                (memToRegM &&
                 (match(writeRegM, rsD, Regfile_weM) || match(writeRegM, rtD, Regfile_weM))));
  end

  // mdStartE is ignored while busy; on the cnt==0 cycle the op leaves EX.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mdStartE) begin
          md_stall = 1'b1;
          state_d  = StMdBusy;
          cnt_d    = CntLoad;
        end
      end
      StMdBusy: begin
        if (cnt_q != '0) begin
          md_stall = 1'b1;
          cnt_d    = cnt_q - CntW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign any_stall = lw_stall || br_stall || md_stall;

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    mdBusy    = 1'b0;
    if (!rst) begin
      stallF = any_stall;
      stallD = any_stall;
      stallE = md_stall;
      // EX is held during a multi-cycle op rather than bubbled.
      flushE = (lw_stall || br_stall) && !md_stall;
      flushM = md_stall;
      flushD = branchTakenD && !any_stall;
      if (match(writeRegM, rsE, Regfile_weM))      forwardAE = 2'b10;
      else if (match(writeRegW, rsE, Regfile_weW)) forwardAE = 2'b01;
      if (match(writeRegM, rtE, Regfile_weM))      forwardBE = 2'b10;
      else if (match(writeRegW, rtE, Regfile_weW)) forwardBE = 2'b01;
      forwardAD = match(writeRegM, rsD, Regfile_weM) && !memToRegM;
      forwardBD = match(writeRegM, rtD, Regfile_weM) && !memToRegM;
      mdBusy    = (state_q == StMdBusy);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] ld_cnt_q, ld_cnt_d;
  logic [31:0] md_cnt_q, md_cnt_d;

  always_comb begin
    ld_cnt_d = ld_cnt_q + {31'd0, (lw_stall || br_stall)};
    md_cnt_d = md_cnt_q + {31'd0, md_stall};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q <= '0;
      md_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign loadStallCnt = rst ? 32'd0 : ld_cnt_q;
  assign mdStallCnt   = rst ? 32'd0 : md_cnt_q;
`endif

endmodule
